// File: rtl/mmio_timer_bank.sv
// Bank of NCH independent prescaled timer channels behind a small CPU register window.
// Each channel has CTRL, PRESCALE, COUNT, COMPARE, STATUS and ID registers at 4-byte spacing.
module mmio_timer_bank #(
    parameter int          NCH      = 4,
    parameter logic [31:0] ID_VALUE = 32'h544D_0000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           sel,
    input  logic           we,
    input  logic [7:0]     addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] tick,
    output logic           irq
);
    localparam logic [31:0] ID_WORD = {ID_VALUE[31:8], 8'(NCH)};

    logic [3:0]  ctrl     [NCH];
    logic [31:0] prescale [NCH];
    logic [31:0] count    [NCH];
    logic [31:0] compare  [NCH];
    logic [31:0] pc       [NCH];
    logic [1:0]  status   [NCH];

    logic [2:0]     reg_idx;
    logic [NCH-1:0] wr_ch;
    logic [NCH-1:0] cnt_wr;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] ovf;
    logic           irq_next;
    logic [31:0]    rd_val;

    assign reg_idx = addr[4:2];

    // A COUNT write in a tick cycle suppresses both the increment and any flag it would raise.
    always_comb begin
        tick     = '0;
        wr_ch    = '0;
        cnt_wr   = '0;
        hit      = '0;
        ovf      = '0;
        irq_next = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            wr_ch[c]  = sel && we && (addr[7:5] == 3'(c));
            cnt_wr[c] = wr_ch[c] && (reg_idx == 3'd2);
            tick[c]   = ctrl[c][0] && (pc[c] == prescale[c]);
            hit[c]    = tick[c] && !cnt_wr[c] && (count[c] == compare[c]);
            ovf[c]    = tick[c] && !cnt_wr[c] && (&count[c])
                        && !(ctrl[c][1] && (count[c] == compare[c]));
            irq_next  = irq_next || (status[c][0] && ctrl[c][2])
                                 || (status[c][1] && ctrl[c][3]);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (addr[7:5] == 3'(c)) begin
                case (reg_idx)
                    3'd0:    rd_val = {28'd0, ctrl[c]};
                    3'd1:    rd_val = prescale[c];
                    3'd2:    rd_val = count[c];
                    3'd3:    rd_val = compare[c];
                    3'd4:    rd_val = {30'd0, status[c]};
                    3'd5:    rd_val = ID_WORD;
                    default: rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
            irq   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                ctrl[c]     <= '0;
                prescale[c] <= '0;
                count[c]    <= '0;
                compare[c]  <= '1;
                pc[c]       <= '0;
                status[c]   <= '0;
            end
        end else begin
            if (sel)
                rdata <= rd_val;
            irq <= irq_next;
            for (int c = 0; c < NCH; c++) begin
                if (wr_ch[c] && (reg_idx == 3'd0))
                    ctrl[c] <= wdata[3:0];
                if (wr_ch[c] && (reg_idx == 3'd1))
                    prescale[c] <= wdata;
                if (wr_ch[c] && (reg_idx == 3'd3))
                    compare[c] <= wdata;

                if (wr_ch[c] && (reg_idx <= 3'd1))
                    pc[c] <= '0;
                else if (ctrl[c][0])
                    pc[c] <= tick[c] ? '0 : pc[c] + 32'd1;

                if (cnt_wr[c])
                    count[c] <= wdata;
                else if (tick[c])
                    count[c] <= (ctrl[c][1] && (count[c] == compare[c])) ? '0 : count[c] + 32'd1;

                // New flag events are ORed in after the clear so a coincident W1C cannot drop them.
                status[c] <= (status[c] & ~((wr_ch[c] && (reg_idx == 3'd4)) ? wdata[1:0] : 2'b00))
                             | {ovf[c], hit[c]};
            end
        end
    end
endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed bench for mmio_timer_bank: register-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_mmio_timer_bank;
    logic        clock;
    logic        reset;
    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  tick;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    mmio_timer_bank #(.NCH(4), .ID_VALUE(32'h544D_0000)) dut (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tick(tick), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the register file as the CPU sees it.
    logic [3:0]  m_ctrl [4];
    logic [31:0] m_pre  [4];
    logic [31:0] m_cnt  [4];
    logic [31:0] m_cmp  [4];
    logic [31:0] m_pc   [4];
    logic [1:0]  m_st   [4];
    logic [31:0] m_rd;
    logic        m_irq;
    bit          fires;
    bit          mine;
    int          r;
    logic [32:0] nxt;
    logic [3:0]  exp_tick;

    function automatic logic [31:0] mreg(input logic [7:0] a);
        int c = int'(a[7:5]);
        int ri = int'(a[4:2]);
        if (c >= 4) return 32'd0;
        case (ri)
            0: return {28'd0, m_ctrl[c]};
            1: return m_pre[c];
            2: return m_cnt[c];
            3: return m_cmp[c];
            4: return {30'd0, m_st[c]};
            5: return 32'h544D_0004;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                m_ctrl[c] = 0; m_pre[c] = 0; m_cnt[c] = 0;
                m_cmp[c] = 32'hFFFF_FFFF; m_pc[c] = 0; m_st[c] = 0;
            end
            m_rd = 0;
            m_irq = 0;
        end else begin
            if (sel) m_rd = mreg(addr);
            m_irq = 0;
            for (int c = 0; c < 4; c++)
                if ((m_st[c][0] && m_ctrl[c][2]) || (m_st[c][1] && m_ctrl[c][3])) m_irq = 1;
            for (int c = 0; c < 4; c++) begin
                fires = m_ctrl[c][0] && (m_pc[c] == m_pre[c]);
                mine  = sel && we && (int'(addr[7:5]) == c);
                r     = int'(addr[4:2]);
                if (mine && r == 4) m_st[c] = m_st[c] & ~wdata[1:0];
                if (m_ctrl[c][0]) m_pc[c] = fires ? 32'd0 : m_pc[c] + 32'd1;
                if (fires && !(mine && r == 2)) begin
                    if (m_cnt[c] == m_cmp[c]) m_st[c][0] = 1'b1;
                    if (m_cnt[c] == m_cmp[c] && m_ctrl[c][1]) m_cnt[c] = 0;
                    else begin
                        nxt = {1'b0, m_cnt[c]} + 33'd1;
                        if (nxt[32]) m_st[c][1] = 1'b1;
                        m_cnt[c] = nxt[31:0];
                    end
                end
                if (mine) begin
                    case (r)
                        0: begin m_ctrl[c] = wdata[3:0]; m_pc[c] = 0; end
                        1: begin m_pre[c] = wdata; m_pc[c] = 0; end
                        2: m_cnt[c] = wdata;
                        3: m_cmp[c] = wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            for (int c = 0; c < 4; c++) exp_tick[c] = m_ctrl[c][0] && (m_pc[c] == m_pre[c]);
            checks++;
            if (rdata !== m_rd) begin
                errors++;
                $display("FAIL model_rdata actual=%h expected=%h t=%0t", rdata, m_rd, $time);
            end
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL model_tick actual=%b expected=%b t=%0t", tick, exp_tick, $time);
            end
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL model_irq actual=%b expected=%b t=%0t", irq, m_irq, $time);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        @(negedge clock);
        sel = 0; we = 0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        sel = 1; we = 0; addr = a;
        @(negedge clock);
        sel = 0;
        lit(name, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; sel = 0; we = 0; addr = 0; wdata = 0;
        cyc();
        chk_on = 1;
        cyc();
        reset = 0;

        // Reset values
        lit("rst_rdata", rdata, 32'd0);
        lit("rst_tick", {28'd0, tick}, 32'd0);
        lit("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk(8'h0C, 32'hFFFF_FFFF, "rst_compare0");
        rd_chk(8'h08, 32'd0, "rst_count0");

        // Channel 0 prescaler period and count
        wr(8'h04, 32'd4);
        wr(8'h00, 32'd1);
        for (int k = 0; k < 20; k++) begin
            lit("tick0_period", {31'd0, tick[0]}, (k % 5 == 4) ? 32'd1 : 32'd0);
            if (k < 19) cyc();
        end
        rd_chk(8'h08, 32'd3, "count0_20clk");
        wr(8'h00, 32'd0);

        // Channel 1 compare match with clear-on-match and W1C
        wr(8'h2C, 32'd2);
        wr(8'h20, 32'd7);
        wr(8'h24, 32'd0);
        lit("irq1_c", {31'd0, irq}, 32'd0);
        cyc(); lit("irq1_d", {31'd0, irq}, 32'd0);
        cyc(); lit("irq1_e", {31'd0, irq}, 32'd0);
        cyc(); lit("irq1_f", {31'd0, irq}, 32'd1);
        wr(8'h30, 32'd1);
        lit("irq1_after_w1c", {31'd0, irq}, 32'd1);
        cyc(); lit("irq1_dropped", {31'd0, irq}, 32'd0);
        wr(8'h20, 32'd0);
        wr(8'h30, 32'd3);

        // Channel 2 overflow
        wr(8'h48, 32'hFFFF_FFFE);
        wr(8'h44, 32'd0);
        wr(8'h40, 32'd9);
        cyc();
        cyc();
        rd_chk(8'h48, 32'd0, "count2_wrapped");
        rd_chk(8'h50, 32'd3, "status2_ovf_match");
        lit("irq2_ovf", {31'd0, irq}, 32'd1);
        wr(8'h40, 32'd0);
        wr(8'h50, 32'd3);

        // COUNT write during tick, W1C during match
        wr(8'h04, 32'd0);
        wr(8'h00, 32'd1);
        wr(8'h08, 32'd100);
        rd_chk(8'h08, 32'd100, "count0_write_wins");
        wr(8'h0C, 32'd103);
        cyc();
        wr(8'h10, 32'd1);
        wr(8'h00, 32'd0);
        rd_chk(8'h10, 32'd1, "status0_set_beats_clear");
        wr(8'h10, 32'd3);

        // Read-during-write, ID, unmapped space
        wr(8'h6C, 32'h0000_1234);
        lit("rdw_prewrite", rdata, 32'hFFFF_FFFF);
        rd_chk(8'h6C, 32'h0000_1234, "compare3_written");
        wr(8'h14, 32'd0);
        lit("id_prewrite", rdata, 32'h544D_0004);
        rd_chk(8'h14, 32'h544D_0004, "id_readonly");
        wr(8'hE0, 32'd5);
        rd_chk(8'hE0, 32'd0, "chan7_zero");
        rd_chk(8'h18, 32'd0, "idx6_zero");

        // Reset while counting with irq raised
        wr(8'h0C, 32'd5);
        wr(8'h08, 32'd5);
        wr(8'h00, 32'd5);
        cyc();
        cyc();
        lit("irq0_pre_reset", {31'd0, irq}, 32'd1);
        reset = 1;
        cyc();
        reset = 0;
        lit("mid_rst_tick", {28'd0, tick}, 32'd0);
        lit("mid_rst_irq", {31'd0, irq}, 32'd0);
        lit("mid_rst_rdata", rdata, 32'd0);
        rd_chk(8'h08, 32'd0, "mid_rst_count0");
        rd_chk(8'h00, 32'd0, "mid_rst_ctrl0");
        rd_chk(8'h0C, 32'hFFFF_FFFF, "mid_rst_compare0");
        rd_chk(8'h10, 32'd0, "mid_rst_status0");
        rd_chk(8'h6C, 32'hFFFF_FFFF, "mid_rst_compare3");
        cyc();

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
